// File: rtl/tlp_header_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tlp_header_assembler
// Brief    : Builds 3DW/4DW PCIe TLP headers from request fields and streams
//            them, followed by pass-through payload, as 32-bit DWs.
// Revision : 1.0 - initial release
// ============================================================================
module tlp_header_assembler #(
  parameter int LINK_NUMBER = 0,
  parameter int DW_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [6:0]          req_fmt_type,
  input  logic [9:0]          req_length,
  input  logic [15:0]         req_requester_id,
  input  logic [7:0]          req_tag,
  input  logic [3:0]          req_first_be,
  input  logic [3:0]          req_last_be,
  input  logic [63:0]         req_addr,
  input  logic [DW_WIDTH-1:0] pl_data,
  input  logic                pl_valid,
  output logic                pl_ready,
  output logic [DW_WIDTH-1:0] out_dw,
  output logic                out_valid,
  output logic                out_sop,
  output logic                out_eop,
  input  logic                next_ready
);

  generate
    if (DW_WIDTH != 32 || LINK_NUMBER < 0) begin : g_bad_cfg
      $error("tlp_header_assembler: DW_WIDTH must be 32 and LINK_NUMBER non-negative");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t      r_state;
  logic [6:0]  r_fmt_type;
  logic [9:0]  r_length;
  logic [15:0] r_rid;
  logic [7:0]  r_tag;
  logic [3:0]  r_first_be;
  logic [3:0]  r_last_be;
  logic [61:0] r_addr;
  logic [1:0]  r_hdr_idx;
  logic [10:0] r_cnt;

  logic        w_is_4dw;
  logic        w_with_data;
  logic        w_last_hdr;
  logic [31:0] w_hdr_dw;
  logic [31:0] w_addr_lo;
  logic [3:0]  w_last_be;
  logic        w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^req_addr[1:0];
  assign w_is_4dw          = r_fmt_type[5];
  assign w_with_data       = r_fmt_type[6];
  assign w_last_hdr        = (r_hdr_idx == (w_is_4dw ? 2'd3 : 2'd2));
  assign w_addr_lo         = {r_addr[29:0], 2'b00};
  // A single-DW TLP must carry a zero last-BE field.
  assign w_last_be         = (r_length == 10'd1) ? 4'b0000 : r_last_be;

  always_comb begin
    w_hdr_dw = 32'd0;
    case (r_hdr_idx)
      2'd0:    w_hdr_dw = {1'b0, r_fmt_type, 14'b0, r_length};
      2'd1:    w_hdr_dw = {r_rid, r_tag, w_last_be, r_first_be};
      2'd2:    w_hdr_dw = w_is_4dw ? r_addr[61:30] : w_addr_lo;
      default: w_hdr_dw = w_addr_lo;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    out_dw    = '0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    pl_ready  = 1'b0;
    case (r_state)
      ST_HDR: begin
        out_valid = 1'b1;
        out_dw    = w_hdr_dw;
        out_sop   = (r_hdr_idx == 2'd0);
        out_eop   = w_last_hdr && !w_with_data;
      end
      ST_PAYLOAD: begin
        out_dw    = pl_data;
        out_valid = pl_valid;
        out_eop   = pl_valid && (r_cnt == 11'd1);
        pl_ready  = pl_valid && next_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fmt_type <= '0;
      r_length   <= '0;
      r_rid      <= '0;
      r_tag      <= '0;
      r_first_be <= '0;
      r_last_be  <= '0;
      r_addr     <= '0;
      r_hdr_idx  <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_fmt_type <= req_fmt_type;
            r_length   <= req_length;
            r_rid      <= req_requester_id;
            r_tag      <= req_tag;
            r_first_be <= req_first_be;
            r_last_be  <= req_last_be;
            r_addr     <= req_addr[63:2];
            r_hdr_idx  <= 2'd0;
            r_state    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (next_ready) begin
            if (w_last_hdr) begin
              // Length 0 encodes 1024 DWs.
              r_cnt   <= {(r_length == 10'd0), r_length};
              r_state <= w_with_data ? ST_PAYLOAD : ST_IDLE;
            end else begin
              r_hdr_idx <= r_hdr_idx + 2'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (pl_valid && next_ready) begin
            r_cnt <= r_cnt - 11'd1;
            if (r_cnt == 11'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlp_header_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlp_header_assembler
// Brief    : Self-checking bench for tlp_header_assembler against a DW-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlp_header_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_fmt_type;
  logic [9:0]  req_length;
  logic [15:0] req_requester_id;
  logic [7:0]  req_tag;
  logic [3:0]  req_first_be;
  logic [3:0]  req_last_be;
  logic [63:0] req_addr;
  logic [31:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] out_dw;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic        next_ready;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] pay [1024];

  always #5 clk = ~clk;

  tlp_header_assembler #(.LINK_NUMBER(0), .DW_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt_type(req_fmt_type), .req_length(req_length),
    .req_requester_id(req_requester_id), .req_tag(req_tag),
    .req_first_be(req_first_be), .req_last_be(req_last_be),
    .req_addr(req_addr),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .out_dw(out_dw), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .next_ready(next_ready)
  );

  // Sends one TLP and checks every cycle against the expected DW list built
  // from the header rules. stall/starve hold next_ready / pl_valid low for n
  // cycles while list entry idx is due; abort_at >= 0 resets after that many DWs.
  task automatic run_tlp(input string nm,
                         input logic [6:0] ft, input logic [9:0] len,
                         input logic [15:0] rid, input logic [7:0] tag,
                         input logic [3:0] fbe, input logic [3:0] lbe,
                         input logic [63:0] addr,
                         input int stall_idx, input int stall_n,
                         input int starve_idx, input int starve_n,
                         input int bp_pct, input int sv_pct, input int abort_at);
    logic [31:0] h [4];
    int nh, npay, total, idx, cyc, budget, plr_seen, st_cnt, sv_cnt;
    logic wd, nr, pv, e_valid, e_sop, e_eop, e_plr;
    logic [31:0] e_dw;
    wd   = ft[6];
    nh   = ft[5] ? 4 : 3;
    npay = wd ? ((len == 0) ? 1024 : int'(len)) : 0;
    total = nh + npay;
    h[0] = (32'(ft) << 24) + 32'(len);
    h[1] = (32'(rid) << 16) + (32'(tag) << 8) + ((len == 1) ? 32'd0 : 32'(lbe) << 4) + 32'(fbe);
    if (nh == 4) begin
      h[2] = addr[63:32];
      h[3] = addr[31:0] & 32'hFFFF_FFFC;
    end else begin
      h[2] = addr[31:0] & 32'hFFFF_FFFC;
      h[3] = 32'd0;
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_fmt_type = ft; req_length = len; req_requester_id = rid;
    req_tag = tag; req_first_be = fbe; req_last_be = lbe; req_addr = addr;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s req_ready_idle: got %b expected 1", nm, req_ready);
    end
    @(posedge clk);

    idx = 0; cyc = 0; plr_seen = 0; st_cnt = 0; sv_cnt = 0;
    budget = 20 * total + 100;
    while (idx < total && cyc < budget && !(abort_at >= 0 && idx == abort_at)) begin
      #1;
      // Requests offered while busy must be ignored.
      req_valid = 1'b1;
      req_fmt_type = 7'($urandom); req_length = 10'($urandom);
      req_requester_id = 16'($urandom); req_tag = 8'($urandom);
      req_first_be = 4'($urandom); req_last_be = 4'($urandom);
      req_addr = {$urandom, $urandom};
      if (idx == stall_idx && st_cnt < stall_n) begin
        nr = 1'b0; st_cnt++;
      end else begin
        nr = ($urandom_range(0, 99) >= bp_pct);
      end
      if (idx == starve_idx && sv_cnt < starve_n) begin
        pv = 1'b0; sv_cnt++;
      end else begin
        pv = ($urandom_range(0, 99) >= sv_pct);
      end
      next_ready = nr;
      pl_valid   = pv;
      pl_data    = (npay == 0) ? 32'($urandom) : pay[(idx < nh) ? 0 : idx - nh];

      if (idx < nh) begin
        e_valid = 1'b1; e_dw = h[idx]; e_sop = (idx == 0);
        e_eop = (idx == nh - 1) && !wd; e_plr = 1'b0;
      end else begin
        e_valid = pv; e_dw = pay[idx - nh]; e_sop = 1'b0;
        e_eop = (idx == total - 1); e_plr = pv && nr;
      end

      @(negedge clk);
      n_chk++;
      if (out_valid !== e_valid) begin
        n_fail++; $display("FAIL %s out_valid[%0d]: got %b expected %b", nm, idx, out_valid, e_valid);
      end
      n_chk++;
      if (pl_ready !== e_plr) begin
        n_fail++; $display("FAIL %s pl_ready[%0d]: got %b expected %b", nm, idx, pl_ready, e_plr);
      end
      n_chk++;
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s req_ready_busy[%0d]: got %b expected 0", nm, idx, req_ready);
      end
      if (e_valid) begin
        n_chk++;
        if (out_dw !== e_dw) begin
          n_fail++; $display("FAIL %s out_dw[%0d]: got %h expected %h", nm, idx, out_dw, e_dw);
        end
        n_chk++;
        if ({out_sop, out_eop} !== {e_sop, e_eop}) begin
          n_fail++; $display("FAIL %s sop_eop[%0d]: got %b%b expected %b%b", nm, idx,
                             out_sop, out_eop, e_sop, e_eop);
        end
      end
      if (pl_ready === 1'b1) plr_seen++;
      if (e_valid && nr) idx++;
      @(posedge clk);
      cyc++;
    end

    n_chk++;
    if (cyc >= budget) begin
      n_fail++; $display("FAIL %s timeout: got %0d DWs expected %0d", nm, idx, total);
    end

    if (abort_at >= 0) begin
      #1 rst = 1'b1; next_ready = 1'b1; pl_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({out_valid, pl_ready, req_ready} !== 3'b001) begin
        n_fail++; $display("FAIL %s after_abort: got v/plr/rr=%b%b%b expected 001", nm,
                           out_valid, pl_ready, req_ready);
      end
    end else begin
      #1 req_valid = 1'b0; pl_valid = 1'b0; next_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({req_ready, out_valid} !== 2'b10) begin
        n_fail++; $display("FAIL %s after_eop: got rr/v=%b%b expected 10", nm, req_ready, out_valid);
      end
      n_chk++;
      if (plr_seen != npay) begin
        n_fail++; $display("FAIL %s pl_ready_count: got %0d expected %0d", nm, plr_seen, npay);
      end
    end
    pl_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; pl_valid = 1'b1; next_ready = 1'b1;
    pl_data = 32'h1234_5678;
    req_fmt_type = 7'h60; req_length = 10'd2; req_requester_id = 16'hFFFF;
    req_tag = 8'hFF; req_first_be = 4'hF; req_last_be = 4'hF; req_addr = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready, out_valid, out_sop, out_eop, pl_ready} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_flags: got rr/v/sop/eop/plr=%b%b%b%b%b expected 10000",
                         req_ready, out_valid, out_sop, out_eop, pl_ready);
    end
    n_chk++;
    if (out_dw !== 32'd0) begin
      n_fail++; $display("FAIL reset_out_dw: got %h expected 00000000", out_dw);
    end
    #1 req_valid = 1'b0; pl_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_mrd_3dw();
    run_tlp("mrd3", 7'h00, 10'd1, 16'h0100, 8'h05, 4'hF, 4'hF, 64'h0000_0000_FFFF_FFFF,
            -1, 0, -1, 0, 0, 0, -1);
  endtask

  task automatic test_mwr_4dw();
    pay[0] = 32'hDEADBEEF; pay[1] = 32'hCAFEF00D;
    run_tlp("mwr4", 7'h60, 10'd2, 16'h0200, 8'h11, 4'hF, 4'hF, 64'h0000_0001_2345_6788,
            -1, 0, -1, 0, 0, 0, -1);
  endtask

  task automatic test_backpressure();
    run_tlp("bp", 7'h00, 10'd1, 16'h0100, 8'h05, 4'hF, 4'hF, 64'h0000_0000_FFFF_FFFF,
            1, 3, -1, 0, 0, 0, -1);
  endtask

  task automatic test_starvation();
    pay[0] = 32'hDEADBEEF; pay[1] = 32'hCAFEF00D;
    run_tlp("starve", 7'h60, 10'd2, 16'h0200, 8'h11, 4'hF, 4'hF, 64'h0000_0001_2345_6788,
            -1, 0, 5, 2, 0, 0, -1);
  endtask

  task automatic test_len0();
    for (int i = 0; i < 1024; i++) pay[i] = $urandom;
    run_tlp("len0", 7'h40, 10'd0, 16'hABCD, 8'h42, 4'h3, 4'hC, 64'h0000_0000_1000_0004,
            -1, 0, -1, 0, 0, 0, -1);
  endtask

  task automatic test_reset_mid_payload();
    for (int i = 0; i < 4; i++) pay[i] = $urandom;
    run_tlp("rst_mid", 7'h60, 10'd4, 16'h0300, 8'h22, 4'hF, 4'hF, 64'h0000_0002_0000_0010,
            -1, 0, -1, 0, 0, 0, 5);
    run_tlp("post_rst", 7'h00, 10'd1, 16'h0100, 8'h05, 4'hF, 4'hF, 64'h0000_0000_FFFF_FFFF,
            -1, 0, -1, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    logic [6:0] ft;
    logic [9:0] len;
    for (int t = 0; t < 25; t++) begin
      ft  = 7'($urandom);
      len = 10'($urandom_range(1, 16));
      if (t % 5 == 0) len = 10'd1;
      for (int i = 0; i < 16; i++) pay[i] = $urandom;
      run_tlp("rand", ft, len, 16'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
              {$urandom, $urandom}, -1, 0, -1, 0, 30, 25, -1);
    end
  endtask

  initial begin
    test_reset();
    test_mrd_3dw();
    test_mwr_4dw();
    test_backpressure();
    test_starvation();
    test_len0();
    test_reset_mid_payload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
